// File: rtl/onehot_gen.sv
// onehot_gen -- one-hot / thermometer / walking-bit mask generator.
//
// Accepts a {pos, mode, len} request in IDLE and presents a registered mask
// one cycle later on a valid/ready output channel. ONEHOT (and reserved mode 3)
// and THERMO produce one beat. WALK produces max(len,1) beats. The mask rotates
// left by one bit on each output handshake.
//
// Parameters:
//   WIDTH  mask width in bits (>= 2)
//   CNT_W  width of the walk-length field
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   req_valid_i  request valid
//   req_ready_o  request ready (IDLE only, low during reset)
//   req_pos_i    bit position, unsigned
//   req_mode_i   0 ONEHOT, 1 THERMO, 2 WALK, 3 reserved (as ONEHOT)
//   req_len_i    WALK beat count, 0 treated as 1
//   out_valid_o  mask valid
//   out_ready_i  consumer ready
//   out_mask_o   generated mask
//   out_last_o   final beat of the current request
//   err_o        out-of-range flag, qualified by out_valid_o
//
// Build option: define ONEHOT_GEN_OOR_ERR_EN to turn an out-of-range position
// (any mode) into a single zero-mask beat with err_o=1. When the macro is
// undefined, err_o is tied low and out-of-range positions follow shift
// semantics.
module onehot_gen #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [31:0]      req_pos_i,
   input  logic [1:0]       req_mode_i,
   input  logic [CNT_W-1:0] req_len_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_mask_o,
   output logic             out_last_o,
   output logic             err_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      WALK = 2'd2
   } state_t;

   state_t            state, state_next;
   logic [WIDTH-1:0]  mask, mask_next;
   logic [CNT_W-1:0]  cnt, cnt_next;
   logic              ready_q;
   logic [WIDTH-1:0]  onehot_v, thermo_v;
   logic              accept;
`ifdef ONEHOT_GEN_OOR_ERR_EN
   logic              err, err_next;
   logic              oor;
`endif

   // Bitwise compare against pos. This gives shift semantics for free:
   // pos >= WIDTH yields an all-zero one-hot and an all-ones thermometer.
   always_comb begin
      onehot_v = '0;
      thermo_v = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         onehot_v[i] = (req_pos_i == 32'(i));
         thermo_v[i] = (32'(i) <= req_pos_i);
      end
   end

   assign accept = req_valid_i && ready_q;
`ifdef ONEHOT_GEN_OOR_ERR_EN
   assign oor = (req_pos_i >= 32'(WIDTH));
`endif

   always_comb begin
      state_next = state;
      mask_next  = mask;
      cnt_next   = cnt;
`ifdef ONEHOT_GEN_OOR_ERR_EN
      err_next   = err;
`endif
      unique case (state)
         IDLE: begin
            if (accept) begin
`ifdef ONEHOT_GEN_OOR_ERR_EN
               err_next = 1'b0;
               if (oor) begin
                  state_next = HOLD;
                  mask_next  = '0;
                  err_next   = 1'b1;
               end else
`endif
               begin
                  unique case (req_mode_i)
                     2'd1: begin
                        state_next = HOLD;
                        mask_next  = thermo_v;
                     end
                     2'd2: begin
                        state_next = WALK;
                        mask_next  = onehot_v;
                        cnt_next   = (req_len_i == '0) ? CNT_W'(1) : req_len_i;
                     end
                     default: begin
                        state_next = HOLD;
                        mask_next  = onehot_v;
                     end
                  endcase
               end
            end
         end
         HOLD: begin
            if (out_ready_i) begin
               state_next = IDLE;
               mask_next  = '0;
`ifdef ONEHOT_GEN_OOR_ERR_EN
               err_next   = 1'b0;
`endif
            end
         end
         WALK: begin
            if (out_ready_i) begin
               if (cnt == CNT_W'(1)) begin
                  state_next = IDLE;
                  mask_next  = '0;
                  cnt_next   = '0;
`ifdef ONEHOT_GEN_OOR_ERR_EN
                  err_next   = 1'b0;
`endif
               end else begin
                  mask_next = {mask[WIDTH-2:0], mask[WIDTH-1]};
                  cnt_next  = cnt - CNT_W'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         mask    <= '0;
         cnt     <= '0;
         ready_q <= 1'b0;
`ifdef ONEHOT_GEN_OOR_ERR_EN
         err     <= 1'b0;
`endif
      end else begin
         state   <= state_next;
         mask    <= mask_next;
         cnt     <= cnt_next;
         // Registered ready keeps it low throughout reset and high only in IDLE.
         ready_q <= (state_next == IDLE);
`ifdef ONEHOT_GEN_OOR_ERR_EN
         err     <= err_next;
`endif
      end
   end

   assign req_ready_o = ready_q;
   assign out_valid_o = (state != IDLE);
   assign out_mask_o  = mask;
   assign out_last_o  = (state == HOLD) || ((state == WALK) && (cnt == CNT_W'(1)));
`ifdef ONEHOT_GEN_OOR_ERR_EN
   assign err_o       = err;
`else
   assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_gen.sv
// Testbench for onehot_gen (WIDTH=32, CNT_W=8): table-driven single-beat
// requests plus hand-written WALK, backpressure, reset and out-of-range
// sequences. Expectations for the out-of-range cases follow
// ONEHOT_GEN_OOR_ERR_EN.
module tb_onehot_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_pos;
   logic [1:0]  req_mode;
   logic [7:0]  req_len;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_mask;
   logic        out_last;
   logic        err;

   int checks = 0;
   int errors = 0;

   onehot_gen #(.WIDTH(32), .CNT_W(8)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_pos_i   (req_pos),
      .req_mode_i  (req_mode),
      .req_len_i   (req_len),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_mask_o  (out_mask),
      .out_last_o  (out_last),
      .err_o       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] pos;
      logic [7:0]  len;
      logic [31:0] mask;
      logic        last;
      logic        err;
   } vec_t;

   vec_t vecs[10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic single(input string name, input logic [1:0] mode, input logic [31:0] pos,
                         input logic [7:0] len, input logic [31:0] em, input logic ee);
      check($sformatf("%s.idle_ready", name), {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_mode  = mode;
      req_pos   = pos;
      req_len   = len;
      out_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      req_pos   = 32'h0000_0003;
      req_mode  = 2'd1;
      check($sformatf("%s.valid", name), {31'd0, out_valid}, 32'd1);
      check($sformatf("%s.mask", name), out_mask, em);
      check($sformatf("%s.last", name), {31'd0, out_last}, 32'd1);
      check($sformatf("%s.err", name), {31'd0, err}, {31'd0, ee});
      check($sformatf("%s.busy_ready", name), {31'd0, req_ready}, 32'd0);
      tick();
      check($sformatf("%s.done_valid", name), {31'd0, out_valid}, 32'd0);
      check($sformatf("%s.done_ready", name), {31'd0, req_ready}, 32'd1);
   endtask

   logic [31:0] bp_mask [6];
   logic        bp_rdy  [6];
   logic        bp_last [6];
   logic [31:0] walk_mask [4];

   initial begin
`ifdef ONEHOT_GEN_OOR_ERR_EN
      localparam logic OOR_ERR = 1'b1;
      localparam logic [31:0] OOR_THERMO = 32'h0000_0000;
`else
      localparam logic OOR_ERR = 1'b0;
      localparam logic [31:0] OOR_THERMO = 32'hFFFF_FFFF;
`endif
      vecs[0] = '{2'd0, 32'd5,  8'd0, 32'h0000_0020, 1'b1, 1'b0};
      vecs[1] = '{2'd0, 32'd12, 8'd0, 32'h0000_1000, 1'b1, 1'b0};
      vecs[2] = '{2'd1, 32'd3,  8'd0, 32'h0000_000F, 1'b1, 1'b0};
      vecs[3] = '{2'd1, 32'd31, 8'd0, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[4] = '{2'd1, 32'd0,  8'd0, 32'h0000_0001, 1'b1, 1'b0};
      vecs[5] = '{2'd2, 32'd9,  8'd0, 32'h0000_0200, 1'b1, 1'b0};
      vecs[6] = '{2'd3, 32'd17, 8'd0, 32'h0002_0000, 1'b1, 1'b0};
      vecs[7] = '{2'd0, 32'd31, 8'd0, 32'h8000_0000, 1'b1, 1'b0};
      vecs[8] = '{2'd0, 32'd40, 8'd0, 32'h0000_0000, 1'b1, OOR_ERR};
      vecs[9] = '{2'd1, 32'd40, 8'd0, OOR_THERMO,    1'b1, OOR_ERR};

      walk_mask = '{32'h4000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0002};
      bp_rdy  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      bp_mask = '{32'h1, 32'h1, 32'h1, 32'h2, 32'h2, 32'h4};
      bp_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      rst = 1'b1; req_valid = 1'b0; req_pos = '0; req_mode = '0; req_len = '0; out_ready = 1'b0;
      tick();
      tick();
      check("rst.ready", {31'd0, req_ready}, 32'd0);
      check("rst.valid", {31'd0, out_valid}, 32'd0);
      check("rst.mask",  out_mask, 32'd0);
      check("rst.last",  {31'd0, out_last}, 32'd0);
      check("rst.err",   {31'd0, err}, 32'd0);
      rst = 1'b0;
      tick();
      check("post_rst.ready", {31'd0, req_ready}, 32'd1);

      // Table-driven single-beat requests, back to back at 2-cycle spacing.
      for (int i = 0; i < 10; i++)
         single($sformatf("vec%0d", i), vecs[i].mode, vecs[i].pos, vecs[i].len,
                vecs[i].mask, vecs[i].err);

      // WALK pos 30 len 4, ready held high: one beat per cycle with wrap.
      req_valid = 1'b1; req_mode = 2'd2; req_pos = 32'd30; req_len = 8'd4; out_ready = 1'b1;
      tick();
      req_valid = 1'b0; req_len = 8'd77;
      for (int b = 0; b < 4; b++) begin
         check($sformatf("walk.valid%0d", b), {31'd0, out_valid}, 32'd1);
         check($sformatf("walk.mask%0d", b), out_mask, walk_mask[b]);
         check($sformatf("walk.last%0d", b), {31'd0, out_last}, (b == 3) ? 32'd1 : 32'd0);
         check($sformatf("walk.ready%0d", b), {31'd0, req_ready}, 32'd0);
         tick();
      end
      check("walk.end_valid", {31'd0, out_valid}, 32'd0);

      // WALK pos 0 len 3 under backpressure. Output must hold while not ready.
      check("bp.idle_ready", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_mode = 2'd2; req_pos = 32'd0; req_len = 8'd3; out_ready = 1'b0;
      tick();
      req_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         out_ready = bp_rdy[c];
         check($sformatf("bp.valid%0d", c), {31'd0, out_valid}, 32'd1);
         check($sformatf("bp.mask%0d", c), out_mask, bp_mask[c]);
         check($sformatf("bp.last%0d", c), {31'd0, out_last}, {31'd0, bp_last[c]});
         check($sformatf("bp.ready%0d", c), {31'd0, req_ready}, 32'd0);
         tick();
      end
      check("bp.end_valid", {31'd0, out_valid}, 32'd0);

      // HOLD stalled with a competing request on the input: it must be ignored.
      req_valid = 1'b1; req_mode = 2'd0; req_pos = 32'd3; req_len = 8'd0; out_ready = 1'b0;
      tick();
      req_pos = 32'd20; req_mode = 2'd1;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("hold.mask%0d", c), out_mask, 32'h0000_0008);
         check($sformatf("hold.last%0d", c), {31'd0, out_last}, 32'd1);
         check($sformatf("hold.ready%0d", c), {31'd0, req_ready}, 32'd0);
         tick();
      end
      req_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check("hold.end_valid", {31'd0, out_valid}, 32'd0);

      // Reset on beat 2 of WALK len 8 aborts the sequence.
      req_valid = 1'b1; req_mode = 2'd2; req_pos = 32'd0; req_len = 8'd8; out_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      check("abort.beat1", out_mask, 32'h1);
      tick();
      check("abort.beat2", out_mask, 32'h2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort.valid", {31'd0, out_valid}, 32'd0);
      check("abort.mask",  out_mask, 32'd0);
      check("abort.last",  {31'd0, out_last}, 32'd0);
      check("abort.ready", {31'd0, req_ready}, 32'd0);
      tick();
      check("abort.idle_valid", {31'd0, out_valid}, 32'd0);
      single("after_abort", 2'd0, 32'd7, 8'd0, 32'h0000_0080, 1'b0);

      // Out-of-range WALK pos 40 len 5.
      req_valid = 1'b1; req_mode = 2'd2; req_pos = 32'd40; req_len = 8'd5; out_ready = 1'b1;
      tick();
      req_valid = 1'b0;
`ifdef ONEHOT_GEN_OOR_ERR_EN
      check("oorwalk.valid", {31'd0, out_valid}, 32'd1);
      check("oorwalk.mask",  out_mask, 32'd0);
      check("oorwalk.last",  {31'd0, out_last}, 32'd1);
      check("oorwalk.err",   {31'd0, err}, 32'd1);
      tick();
`else
      for (int b = 0; b < 5; b++) begin
         check($sformatf("oorwalk.valid%0d", b), {31'd0, out_valid}, 32'd1);
         check($sformatf("oorwalk.mask%0d", b), out_mask, 32'd0);
         check($sformatf("oorwalk.last%0d", b), {31'd0, out_last}, (b == 4) ? 32'd1 : 32'd0);
         check($sformatf("oorwalk.err%0d", b), {31'd0, err}, 32'd0);
         tick();
      end
`endif
      check("oorwalk.end_valid", {31'd0, out_valid}, 32'd0);
      check("oorwalk.end_ready", {31'd0, req_ready}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
